// File: rtl/cobalt_pkg.sv
// cobalt_pkg: widths, requester indices and the default fixed-latency mask shared
// by the CDB arbiter and its neighbours (register status table, reservation stations).
package cobalt_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    localparam int REQ_INT  = 0;
    localparam int REQ_LS   = 1;
    localparam int REQ_MULT = 2;
    localparam int REQ_DIV  = 3;

    // Only the multiplier pipeline is fixed-latency and cannot be stalled.
    localparam logic [3:0] FIXED_MASK_DEFAULT = 4'b0100;

    localparam int AGE_MAX_DEFAULT = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational one-hot round-robin pick, searching upward from
// ptr and wrapping to 0. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);

    localparam int PTR_W = $clog2(N);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one writeback requester per cycle and registers it onto the CDB.
// Define CDB_AGING_EN to add per-requester wait counters and the cdb_fixed_hold request.
module cdb_arbiter #(
    parameter int               N_REQ      = 4,
    parameter int               TAG_W      = cobalt_pkg::TAG_W,
    parameter int               DATA_W     = cobalt_pkg::DATA_W,
    parameter logic [N_REQ-1:0] FIXED_MASK = cobalt_pkg::FIXED_MASK_DEFAULT
`ifdef CDB_AGING_EN
    ,
    parameter int               AGE_MAX    = cobalt_pkg::AGE_MAX_DEFAULT
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_gnt,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [$clog2(N_REQ)-1:0]  cdb_src,
    output logic                      collision_err,
    output logic                      cdb_fixed_hold
);

    import cobalt_pkg::*;

    localparam int SRC_W = $clog2(N_REQ);

    logic [SRC_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  fixed_req, flex_req, fixed_gnt, rr_req, rr_gnt, gnt;
    logic [SRC_W-1:0]  win_idx;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;

    assign fixed_req = req_valid & FIXED_MASK;
    assign flex_req  = req_valid & ~FIXED_MASK;
    // Lowest set bit; any other fixed bit still set means a fixed collision.
    assign fixed_gnt = fixed_req & (-fixed_req);

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req (rr_req),
        .ptr (rr_ptr),
        .gnt (rr_gnt)
    );

    always_comb begin
        gnt = '0;
        if (reset) begin
            if (|fixed_req) gnt = fixed_gnt;
            else            gnt = rr_gnt;
        end
    end

    assign req_gnt = gnt;

    always_comb begin
        win_idx  = '0;
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                win_idx  = SRC_W'(i);
                win_tag  = req_tag[i*TAG_W +: TAG_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Idle cycles broadcast zeros; the pointer only moves on a round-robin win.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cdb_valid     <= 1'b0;
            cdb_tag       <= '0;
            cdb_data      <= '0;
            cdb_src       <= '0;
            rr_ptr        <= '0;
            collision_err <= 1'b0;
        end else begin
            cdb_valid <= |gnt;
            cdb_tag   <= win_tag;
            cdb_data  <= win_data;
            cdb_src   <= win_idx;
            if (|gnt && !(|fixed_req))
                rr_ptr <= (win_idx == SRC_W'(N_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
            if (fixed_req != fixed_gnt)
                collision_err <= 1'b1;
        end
    end

`ifdef CDB_AGING_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic [AGE_W-1:0] wait_cnt [N_REQ];
    logic [AGE_W-1:0] wait_nxt [N_REQ];
    logic [N_REQ-1:0] aged, aged_nxt, aged_req;

    always_comb begin
        aged = '0;
        for (int i = 0; i < N_REQ; i++)
            aged[i] = !FIXED_MASK[i] && (wait_cnt[i] == AGE_W'(AGE_MAX));
    end

    // Saturated waiters form a priority class searched from rr_ptr like plain RR.
    assign aged_req = aged & flex_req;
    assign rr_req   = (|aged_req) ? aged_req : flex_req;

    always_comb begin
        aged_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (FIXED_MASK[i] || !req_valid[i] || gnt[i]) wait_nxt[i] = '0;
            else if (aged[i])                             wait_nxt[i] = wait_cnt[i];
            else                                          wait_nxt[i] = wait_cnt[i] + AGE_W'(1);
            aged_nxt[i] = !FIXED_MASK[i] && (wait_nxt[i] == AGE_W'(AGE_MAX));
        end
    end

    // Hold tracks the counters as registered, so it drops the cycle after the aged grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= '0;
            cdb_fixed_hold <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= wait_nxt[i];
            cdb_fixed_hold <= |aged_nxt;
        end
    end
`else
    assign rr_req         = flex_req;
    assign cdb_fixed_hold = 1'b0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of cdb_arbiter grant, CDB latency, round-robin,
// fixed priority, collision and (with CDB_AGING_EN) aging/hold behaviour.
module tb_cdb_arbiter;

    import cobalt_pkg::*;

`ifdef CDB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [23:0] req_tag;
    logic [127:0] req_data;

    logic [3:0]  req_gnt,  req_gnt_b;
    logic        cdb_valid, cdb_valid_b;
    logic [5:0]  cdb_tag,  cdb_tag_b;
    logic [31:0] cdb_data, cdb_data_b;
    logic [1:0]  cdb_src,  cdb_src_b;
    logic        collision_err, collision_err_b;
    logic        cdb_fixed_hold, cdb_fixed_hold_b;

    int checks;
    int failures;

    cdb_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_tag        (req_tag),
        .req_data       (req_data),
        .req_gnt        (req_gnt),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_src        (cdb_src),
        .collision_err  (collision_err),
        .cdb_fixed_hold (cdb_fixed_hold)
    );

    // Second instance treats ld/st and mult as fixed so the two can collide.
    cdb_arbiter #(.FIXED_MASK(4'b0110)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_tag        (req_tag),
        .req_data       (req_data),
        .req_gnt        (req_gnt_b),
        .cdb_valid      (cdb_valid_b),
        .cdb_tag        (cdb_tag_b),
        .cdb_data       (cdb_data_b),
        .cdb_src        (cdb_src_b),
        .collision_err  (collision_err_b),
        .cdb_fixed_hold (cdb_fixed_hold_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_req(input int i, input logic [5:0] tag, input logic [31:0] data);
        req_tag[i*TAG_W +: TAG_W]    = tag;
        req_data[i*DATA_W +: DATA_W] = data;
    endtask

    task automatic reset_dut();
        reset     = 1'b0;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        reset     = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, 6'(10 + i), 32'hA000_0000 + i);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_gnt !== 4'b0000) begin
                failures++;
                $display("[TB] FAIL reset_gnt cycle %0d: got %b expected 0000", c, req_gnt);
            end
            checks++;
            if ({cdb_valid, cdb_tag, cdb_data, cdb_src, collision_err, cdb_fixed_hold} !== '0) begin
                failures++;
                $display("[TB] FAIL reset_outputs cycle %0d: valid=%b tag=%h data=%h src=%0d coll=%b hold=%b expected all 0",
                         c, cdb_valid, cdb_tag, cdb_data, cdb_src, collision_err, cdb_fixed_hold);
            end
            checks++;
            if (req_gnt_b !== 4'b0000 || collision_err_b !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_b cycle %0d: gnt=%b coll=%b expected 0000/0", c, req_gnt_b, collision_err_b);
            end
            @(posedge clk); #1;
        end
        reset     = 1'b1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_src, collision_err, cdb_fixed_hold} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_release: valid=%b tag=%h data=%h src=%0d expected all 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
    endtask

    task automatic test_single();
        reset_dut();
        set_req(REQ_INT, 6'd5, 32'hDEAD_BEEF);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_gnt !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL single_gnt: got %b expected 0001", req_gnt);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'd5 || cdb_data !== 32'hDEAD_BEEF || cdb_src !== 2'd0) begin
            failures++;
            $display("[TB] FAIL single_cdb: valid=%b tag=%0d data=%h src=%0d expected 1/5/deadbeef/0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
        checks++;
        if (req_gnt !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL idle_gnt: got %b expected 0000", req_gnt);
        end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 6'd0 || cdb_data !== 32'd0 || cdb_src !== 2'd0) begin
            failures++;
            $display("[TB] FAIL idle_cdb: valid=%b tag=%0d data=%h src=%0d expected 0/0/0/0",
                     cdb_valid, cdb_tag, cdb_data, cdb_src);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        logic [1:0] exp_s [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        reset_dut();
        for (int i = 0; i < 4; i++) set_req(i, 6'(10 + i), 32'hC000_0000 + i);
        req_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (req_gnt !== exp_g[k]) begin
                failures++;
                $display("[TB] FAIL rr_gnt step %0d: got %b expected %b", k, req_gnt, exp_g[k]);
            end
            if (k > 0) begin
                checks++;
                if (cdb_valid !== 1'b1 || cdb_src !== exp_s[k-1] || cdb_tag !== 6'(10 + exp_s[k-1])
                    || cdb_data !== 32'hC000_0000 + exp_s[k-1]) begin
                    failures++;
                    $display("[TB] FAIL rr_cdb step %0d: valid=%b src=%0d tag=%0d data=%h expected src %0d",
                             k, cdb_valid, cdb_src, cdb_tag, cdb_data, exp_s[k-1]);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 4'b0000;
        #1;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd3 || cdb_tag !== 6'd13) begin
            failures++;
            $display("[TB] FAIL rr_last_cdb: valid=%b src=%0d tag=%0d expected 1/3/13", cdb_valid, cdb_src, cdb_tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_fixed_priority();
        logic [3:0] vld   [4] = '{4'b0011, 4'b0111, 4'b0011, 4'b0011};
        logic [3:0] exp_g [4] = '{4'b0001, 4'b0100, 4'b0010, 4'b0001};
        logic [1:0] exp_s [4] = '{2'd0, 2'd2, 2'd1, 2'd0};
        reset_dut();
        for (int i = 0; i < 4; i++) set_req(i, 6'(20 + i), 32'hF000_0000 + i);
        for (int k = 0; k < 4; k++) begin
            req_valid = vld[k];
            #1;
            checks++;
            if (req_gnt !== exp_g[k]) begin
                failures++;
                $display("[TB] FAIL fixed_gnt step %0d: got %b expected %b", k, req_gnt, exp_g[k]);
            end
            if (k > 0) begin
                checks++;
                if (cdb_valid !== 1'b1 || cdb_src !== exp_s[k-1] || cdb_tag !== 6'(20 + exp_s[k-1])) begin
                    failures++;
                    $display("[TB] FAIL fixed_cdb step %0d: valid=%b src=%0d tag=%0d expected src %0d",
                             k, cdb_valid, cdb_src, cdb_tag, exp_s[k-1]);
                end
            end
            @(posedge clk); #1;
        end
        req_valid = 4'b0000;
        #1;
        checks++;
        if (cdb_src !== 2'd0 || cdb_data !== 32'hF000_0000) begin
            failures++;
            $display("[TB] FAIL fixed_last_cdb: src=%0d data=%h expected 0/f0000000", cdb_src, cdb_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_collision();
        reset_dut();
        for (int i = 0; i < 4; i++) set_req(i, 6'(30 + i), 32'hB000_0000 + i);
        req_valid = 4'b0110;
        #1;
        checks++;
        if (collision_err_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coll_pre: got %b expected 0", collision_err_b);
        end
        checks++;
        if (req_gnt_b !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL coll_gnt: got %b expected 0010", req_gnt_b);
        end
        checks++;
        if (req_gnt !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL coll_single_fixed_gnt: got %b expected 0100", req_gnt);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        #1;
        checks++;
        if (cdb_valid_b !== 1'b1 || cdb_src_b !== 2'd1 || cdb_tag_b !== 6'd31 || cdb_data_b !== 32'hB000_0001) begin
            failures++;
            $display("[TB] FAIL coll_cdb: valid=%b src=%0d tag=%0d data=%h expected 1/1/31/b0000001",
                     cdb_valid_b, cdb_src_b, cdb_tag_b, cdb_data_b);
        end
        checks++;
        if (collision_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coll_no_err_a: got %b expected 0", collision_err);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (collision_err_b !== 1'b1 || cdb_fixed_hold_b !== 1'b0) begin
                failures++;
                $display("[TB] FAIL coll_sticky cycle %0d: err=%b hold=%b expected 1/0", c, collision_err_b, cdb_fixed_hold_b);
            end
            @(posedge clk); #1;
        end
        reset_dut();
        #1;
        checks++;
        if (collision_err_b !== 1'b0) begin
            failures++;
            $display("[TB] FAIL coll_cleared: got %b expected 0", collision_err_b);
        end
    endtask

    task automatic test_aging();
        logic exp_hold;
        reset_dut();
        for (int i = 0; i < 4; i++) set_req(i, 6'(40 + i), 32'hE000_0000 + i);
        req_valid = 4'b1100;
        for (int k = 0; k < 10; k++) begin
            exp_hold = AGING && (k >= 8);
            #1;
            checks++;
            if (req_gnt !== 4'b0100) begin
                failures++;
                $display("[TB] FAIL age_gnt cycle %0d: got %b expected 0100", k, req_gnt);
            end
            checks++;
            if (cdb_fixed_hold !== exp_hold) begin
                failures++;
                $display("[TB] FAIL age_hold cycle %0d: got %b expected %b", k, cdb_fixed_hold, exp_hold);
            end
            @(posedge clk); #1;
        end
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_gnt !== 4'b1000 || cdb_fixed_hold !== AGING) begin
            failures++;
            $display("[TB] FAIL age_div_gnt: gnt=%b hold=%b expected 1000/%b", req_gnt, cdb_fixed_hold, AGING);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        #1;
        checks++;
        if (cdb_src !== 2'd3 || cdb_tag !== 6'd43 || cdb_fixed_hold !== 1'b0) begin
            failures++;
            $display("[TB] FAIL age_release: src=%0d tag=%0d hold=%b expected 3/43/0", cdb_src, cdb_tag, cdb_fixed_hold);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        req_valid = 4'b0000;
        req_tag   = '0;
        req_data  = '0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_priority();
        test_collision();
        test_aging();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
